// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//
// Serial front end for the 4-bit parity checker. It receives framed serial
// nibbles on a single line and presents them in parallel.
// Frame format, LSB first in time: start(0), A, B, C, D, P, stop(1).
// The line idles high. Parity is not evaluated here. Only framing faults are
// flagged.
//
// Parameters
//   BIT_CYCLES : clock cycles per serial bit (even, >= 4)
//   CNT_W      : width of the good-frame counter
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   rx           in   1      asynchronous serial line, idle high
//   A,B,C,D      out  1 ea   data bits of the last good frame, registered
//   P            out  1      parity bit of the last good frame, registered
//   frame_valid  out  1      1-cycle pulse when A..D/P have just been updated
//   framing_err  out  1      1-cycle pulse when the stop bit was sampled 0
//   frame_cnt    out  CNT_W  count of good frames, wraps
// -----------------------------------------------------------------------------
module parity_frame_rx #(
   parameter int BIT_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             P,
   output logic             frame_valid,
   output logic             framing_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int BC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   // Last count of a full bit period. Sampling at this count lands mid-bit.
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CYCLES - 1);
   // Half a bit period after the start edge. This is where the start bit is re-checked.
   localparam logic [BC_W-1:0] BC_HALF = BC_W'(BIT_CYCLES / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE,
      S_FERR,
      S_BREAK
   } state_t;

   // Two-flop synchronizer. Only rs is used downstream.
   logic sync1_q;
   logic sync2_q;
   logic rs;

   state_t           state_q, state_d;
   logic [BC_W-1:0]  bc_q, bc_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       data_q, data_d;     // data_q[0] = A ... data_q[3] = D
   logic             par_q, par_d;
   logic [4:0]       dout_q, dout_d;     // {A,B,C,D,P}
   logic             fv_q, fv_d;
   logic             fe_q, fe_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mid_bit;

   assign rs      = sync2_q;
   assign mid_bit = (bc_q == BC_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         bc_q    <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         dout_q  <= '0;
         fv_q    <= 1'b0;
         fe_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         state_q <= state_d;
         bc_q    <= bc_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         fv_q    <= fv_d;
         fe_q    <= fe_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bc_d    = bc_q;
      idx_d   = idx_q;
      data_d  = data_q;
      par_d   = par_q;
      dout_d  = dout_q;
      fv_d    = 1'b0;
      fe_d    = 1'b0;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            bc_d = '0;
            if (!rs) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (bc_q == BC_HALF) begin
               bc_d  = '0;
               idx_d = '0;
               // A start bit that has gone away by mid-bit is treated as a glitch.
               state_d = rs ? S_IDLE : S_DATA;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end

         S_DATA: begin
            if (mid_bit) begin
               bc_d          = '0;
               data_d[idx_q] = rs;
               if (idx_q == 2'd3) begin
                  state_d = S_PARITY;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (mid_bit) begin
               bc_d    = '0;
               par_d   = rs;
               state_d = S_STOP;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end

         S_STOP: begin
            if (mid_bit) begin
               bc_d    = '0;
               state_d = rs ? S_DONE : S_FERR;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end

         S_DONE: begin
            dout_d  = {data_q[0], data_q[1], data_q[2], data_q[3], par_q};
            fv_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_IDLE;
         end

         S_FERR: begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
         end

         S_BREAK: begin
            // A line held low must return high before a new start can be seen.
            if (rs) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign A           = dout_q[4];
   assign B           = dout_q[3];
   assign C           = dout_q[2];
   assign D           = dout_q[1];
   assign P           = dout_q[0];
   assign frame_valid = fv_q;
   assign framing_err = fe_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
//
// Directed bench for parity_frame_rx with BIT_CYCLES=4.
// Instance u_dut uses CNT_W=8 and covers the reset, good frame, framing error,
// glitch and back-to-back scenarios.
// Instance u_dut2 uses CNT_W=2. It shares rx with u_dut, is held in reset until
// the wrap test, and covers counter wrap and reset during a frame.
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst2_n;
   logic       rx;

   logic       A, B, C, D, P, fv, fe;
   logic [7:0] cnt;
   logic       A2, B2, C2, D2, P2, fv2, fe2;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int fv_n = 0, fe_n = 0, both_n = 0;
   int fv2_n = 0, fe2_n = 0;
   logic [4:0] fv_val[$];
   int         fv_at[$];
   logic [4:0] last2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   parity_frame_rx #(.BIT_CYCLES(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .A(A), .B(B), .C(C), .D(D), .P(P),
      .frame_valid(fv), .framing_err(fe), .frame_cnt(cnt)
   );

   parity_frame_rx #(.BIT_CYCLES(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .rx(rx),
      .A(A2), .B(B2), .C(C2), .D(D2), .P(P2),
      .frame_valid(fv2), .framing_err(fe2), .frame_cnt(cnt2)
   );

   // Pulse monitor. It prints one line per received frame or framing error.
   always @(negedge clk) begin
      if (fv === 1'b1) begin
         fv_n++;
         fv_val.push_back({A, B, C, D, P});
         fv_at.push_back(cyc);
         $display("dut  frame  cyc=%0d abcdp=%b cnt=%0d", cyc, {A, B, C, D, P}, cnt);
      end
      if (fe === 1'b1) begin
         fe_n++;
         $display("dut  ferr   cyc=%0d", cyc);
      end
      if (fv === 1'b1 && fe === 1'b1) both_n++;
      if (fv2 === 1'b1) begin
         fv2_n++;
         last2 = {A2, B2, C2, D2, P2};
         $display("dut2 frame  cyc=%0d abcdp=%b cnt=%0d", cyc, {A2, B2, C2, D2, P2}, cnt2);
      end
      if (fe2 === 1'b1) begin
         fe2_n++;
         $display("dut2 ferr   cyc=%0d", cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] mk(input logic a, b, c, d, p, stp);
      return {stp, p, d, c, b, a, 1'b0};
   endfunction

   // Drives one frame, 4 cycles per bit.
   // If rst_bit matches a bit index, u_dut2 reset is asserted at the start of that bit.
   task automatic send_frame(input logic [6:0] f, input int rst_bit);
      for (int i = 0; i < 7; i++) begin
         if (i == rst_bit) rst2_n = 1'b0;
         rx = f[i];
         tick(4);
      end
   endtask

   task automatic clear_mon();
      fv_n = 0;
      fe_n = 0;
      fv_val.delete();
      fv_at.delete();
   endtask

   initial begin
      int         start_cyc;
      logic [4:0] obs;
      logic [3:0] nv;

      rst_n  = 1'b0;
      rst2_n = 1'b0;
      rx     = 1'b1;

      // Reset held for 3 cycles while rx toggles.
      for (int i = 0; i < 3; i++) begin
         rx = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
         chk($sformatf("rst_outs%0d", i), {A, B, C, D, P, fv, fe, cnt}, 32'd0);
      end
      rx    = 1'b1;
      rst_n = 1'b1;
      tick(3);
      chk("post_rst_outs", {A, B, C, D, P, fv, fe, cnt}, 32'd0);
      chk("post_rst_pulses", fv_n + fe_n, 32'd0);
      clear_mon();

      // Good frame 10111.
      start_cyc = cyc + 1;
      send_frame(mk(1, 0, 1, 1, 1, 1), -1);
      tick(10);
      chk("good_count", fv_n, 32'd1);
      obs = (fv_val.size() > 0) ? fv_val[0] : 5'bx;
      chk("good_value", obs, 32'b10111);
      chk("good_latency", (fv_at.size() > 0) ? fv_at[0] - start_cyc : -1, 32'd29);
      chk("good_cnt", cnt, 32'd1);
      chk("good_noferr", fe_n, 32'd0);
      clear_mon();

      // Framing error: stop bit 0, then the line held low.
      send_frame(mk(1, 0, 1, 1, 1, 0), -1);
      rx = 1'b0;
      tick(20);
      chk("ferr_count", fe_n, 32'd1);
      chk("ferr_novalid", fv_n, 32'd0);
      chk("ferr_outs_kept", {A, B, C, D, P}, 32'b10111);
      chk("ferr_cnt_kept", cnt, 32'd1);
      rx = 1'b1;
      tick(10);
      chk("ferr_break_quiet", fe_n + fv_n, 32'd1);
      clear_mon();

      // One-cycle glitch, followed by a good frame.
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(10);
      chk("glitch_quiet", fe_n + fv_n, 32'd0);
      send_frame(mk(0, 1, 1, 0, 0, 1), -1);
      tick(10);
      chk("glitch_next_count", fv_n, 32'd1);
      chk("glitch_next_value", {A, B, C, D, P}, 32'b01100);
      chk("glitch_next_cnt", cnt, 32'd2);
      clear_mon();

      // 16 back-to-back frames with even parity.
      for (int v = 0; v < 16; v++) begin
         nv = 4'(v);
         send_frame(mk(nv[3], nv[2], nv[1], nv[0], ^nv, 1'b1), -1);
      end
      tick(10);
      chk("b2b_count", fv_n, 32'd16);
      chk("b2b_ferr", fe_n, 32'd0);
      for (int v = 0; v < 16; v++) begin
         nv  = 4'(v);
         obs = (v < fv_val.size()) ? fv_val[v] : 5'bx;
         chk($sformatf("b2b_val%0d", v), obs, {27'd0, nv, ^nv});
         chk($sformatf("b2b_E%0d", v), ^obs, 32'd0);
      end
      chk("b2b_cnt", cnt, 32'd18);
      chk("never_both", both_n, 32'd0);

      // Counter wrap on the 2-bit instance.
      rx     = 1'b1;
      rst2_n = 1'b1;
      tick(3);
      for (int k = 0; k < 5; k++) begin
         send_frame(mk(1, 1, 0, 0, 0, 1), -1);
         tick(2);
      end
      tick(5);
      chk("wrap_count", fv2_n, 32'd5);
      chk("wrap_cnt", cnt2, 32'd1);
      chk("wrap_value", last2, 32'b11000);

      // Reset asserted during the DATA bits.
      fv2_n = 0;
      fe2_n = 0;
      send_frame(mk(1, 0, 1, 1, 1, 1), 2);
      rx = 1'b1;
      tick(5);
      chk("midrst_pulses", fv2_n + fe2_n, 32'd0);
      chk("midrst_outs", {A2, B2, C2, D2, P2, fv2, fe2, cnt2}, 32'd0);
      rst2_n = 1'b1;
      tick(5);
      chk("midrst_release_outs", {A2, B2, C2, D2, P2, fv2, fe2, cnt2}, 32'd0);
      chk("midrst_release_pulses", fv2_n + fe2_n, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
